// File: rtl/obj_scan_ctrl.sv
// Per-line object scanner: walks the 32 object slots of one RAM bank, picks out
// up to 8 objects covering the prepared line and queues them in an 8-deep FWFT FIFO.
module obj_scan_ctrl (
    input  logic       clkm_48MHZ,
    input  logic       reset,
    input  logic       pix_ce,
    input  logic       line_start,
    input  logic [7:0] vline,
    input  logic       obj_bank,
    input  logic       objon,
    output logic [7:0] obj_addr,
    output logic       obj_rd,
    input  logic [7:0] obj_data,
    output logic       ent_valid,
    input  logic       ent_ready,
    output logic [7:0] ent_x,
    output logic [7:0] ent_code,
    output logic [7:0] ent_attr,
    output logic [3:0] ent_row,
    output logic       line_done,
    output logic       ovf
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_Y    = 3'd1;
    localparam logic [2:0] S_CHK     = 3'd2;
    localparam logic [2:0] S_RD_X    = 3'd3;
    localparam logic [2:0] S_RD_CODE = 3'd4;
    localparam logic [2:0] S_RD_ATTR = 3'd5;
    localparam logic [2:0] S_PUSH    = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    logic [2:0]  state_q, state_d;
    logic [4:0]  slot_q, slot_d;
    logic [3:0]  found_q, found_d;
    logic [7:0]  vline_q, vline_d;
    logic        bank_q, bank_d;
    logic [3:0]  diff_q, diff_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  code_q, code_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    logic [27:0] fifo_mem_q [8];
    logic [27:0] fifo_mem_d [8];
    logic [2:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  wr_ptr_q, wr_ptr_d;
    logic [3:0]  count_q, count_d;

    logic [7:0]  diff_full;
    logic        last_slot;
    logic        advance;
    logic        push;
    logic        pop;
    logic        flush;
    logic [3:0]  row;
    logic [27:0] push_entry;

    // Objects are in range when Y + line wraps into the top 16 codes; the low
    // nibble is then the row within the 16-line sprite.
    assign diff_full  = obj_data + vline_q;
    assign last_slot  = (slot_q == 5'd31);
    assign row        = attr_q[1] ? ~diff_q : diff_q;
    assign push_entry = {x_q, code_q, attr_q, row};

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        found_d = found_q;
        vline_d = vline_q;
        bank_d  = bank_q;
        diff_d  = diff_q;
        x_d     = x_q;
        code_d  = code_q;
        attr_d  = attr_q;
        addr_d  = addr_q;
        rd_d    = 1'b0;
        done_d  = done_q;
        ovf_d   = ovf_q;
        flush   = 1'b0;
        push    = 1'b0;
        advance = 1'b0;
        if (!objon) begin
            state_d = S_IDLE;
            flush   = 1'b1;
        end else if (pix_ce && line_start) begin
            vline_d = vline;
            bank_d  = obj_bank;
            slot_d  = 5'd0;
            found_d = 4'd0;
            ovf_d   = 1'b0;
            done_d  = 1'b0;
            flush   = 1'b1;
            state_d = S_RD_Y;
        end else if (pix_ce) begin
            case (state_q)
                S_RD_Y: begin
                    addr_d  = {bank_q, slot_q, 2'd0};
                    rd_d    = 1'b1;
                    state_d = S_CHK;
                end
                S_CHK: begin
                    diff_d = diff_full[3:0];
                    if (diff_full[7:4] != 4'hF) begin
                        advance = 1'b1;
                    end else if (found_q == 4'd8) begin
                        ovf_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        addr_d  = {bank_q, slot_q, 2'd1};
                        rd_d    = 1'b1;
                        state_d = S_RD_X;
                    end
                end
                S_RD_X: begin
                    x_d     = obj_data;
                    addr_d  = {bank_q, slot_q, 2'd2};
                    rd_d    = 1'b1;
                    state_d = S_RD_CODE;
                end
                S_RD_CODE: begin
                    code_d  = obj_data;
                    addr_d  = {bank_q, slot_q, 2'd3};
                    rd_d    = 1'b1;
                    state_d = S_RD_ATTR;
                end
                S_RD_ATTR: begin
                    attr_d  = obj_data;
                    state_d = S_PUSH;
                end
                S_PUSH: begin
                    push    = 1'b1;
                    found_d = found_q + 4'd1;
                    advance = 1'b1;
                end
                default: begin
                end
            endcase
            if (advance) begin
                if (last_slot) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    slot_d  = slot_q + 5'd1;
                    state_d = S_RD_Y;
                end
            end
        end
    end

    // Pops are independent of pix_ce so the consumer can drain at full clock rate.
    always_comb begin
        pop        = (count_q != 4'd0) && ent_ready;
        fifo_mem_d = fifo_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (flush) begin
            rd_ptr_d = 3'd0;
            wr_ptr_d = 3'd0;
            count_d  = 4'd0;
        end else begin
            if (push) begin
                fifo_mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d             = wr_ptr_q + 3'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 3'd1;
            end
            count_d = count_q + {3'd0, push} - {3'd0, pop};
        end
    end

    always_ff @(posedge clkm_48MHZ) begin
        if (reset) begin
            state_q  <= S_IDLE;
            slot_q   <= 5'd0;
            found_q  <= 4'd0;
            vline_q  <= 8'd0;
            bank_q   <= 1'b0;
            diff_q   <= 4'd0;
            x_q      <= 8'd0;
            code_q   <= 8'd0;
            attr_q   <= 8'd0;
            addr_q   <= 8'd0;
            rd_q     <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_ptr_q <= 3'd0;
            wr_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                fifo_mem_q[i] <= 28'd0;
            end
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            found_q    <= found_d;
            vline_q    <= vline_d;
            bank_q     <= bank_d;
            diff_q     <= diff_d;
            x_q        <= x_d;
            code_q     <= code_d;
            attr_q     <= attr_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            fifo_mem_q <= fifo_mem_d;
        end
    end

    assign obj_addr  = addr_q;
    assign obj_rd    = rd_q;
    assign line_done = done_q;
    assign ovf       = ovf_q;
    assign ent_valid = (count_q != 4'd0);
    assign {ent_x, ent_code, ent_attr, ent_row} = ent_valid ? fifo_mem_q[rd_ptr_q] : 28'd0;

endmodule

// File: tb/tb_obj_scan_ctrl.sv
// Bench for obj_scan_ctrl: a RAM model feeds the scanner while a timeline model,
// built from per-slot tick costs, predicts reads, entries and flags every clock.
module tb_obj_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_ce = 1'b0;
    logic       line_start = 1'b0;
    logic [7:0] vline = 8'd0;
    logic       obj_bank = 1'b0;
    logic       objon = 1'b0;
    logic [7:0] obj_addr;
    logic       obj_rd;
    logic [7:0] obj_data = 8'd0;
    logic       ent_valid;
    logic       ent_ready = 1'b0;
    logic [7:0] ent_x, ent_code, ent_attr;
    logic [3:0] ent_row;
    logic       line_done;
    logic       ovf;

    logic [7:0] ram [256];
    logic [7:0] rd_log [$];
    int         checks = 0;
    int         errors = 0;
    int         phase = 0;
    bit         rand_ready = 1'b0;

    // Model state: a per-line timeline keyed by pix_ce tick after line_start
    logic [7:0]  m_rd_at [int];
    logic [27:0] m_push_at [int];
    logic [27:0] mq [$];
    int          m_tick = 0;
    int          m_done_tick = 0;
    bit          m_active = 1'b0;
    bit          m_ovf_pend = 1'b0;
    bit          model_ok = 1'b0;
    logic        m_rd = 1'b0;
    logic        m_ld = 1'b0;
    logic        m_ovf = 1'b0;
    logic [7:0]  m_addr = 8'd0;
    logic [27:0] m_head;

    bit         was_ce;
    int         ticks;
    int         guard;
    int         mode;
    bit         keep_ram;
    logic [7:0] vl;
    logic       bk;
    logic [7:0] first_rd;

    always #5 clk = ~clk;

    obj_scan_ctrl dut (
        .clkm_48MHZ (clk),
        .reset      (reset),
        .pix_ce     (pix_ce),
        .line_start (line_start),
        .vline      (vline),
        .obj_bank   (obj_bank),
        .objon      (objon),
        .obj_addr   (obj_addr),
        .obj_rd     (obj_rd),
        .obj_data   (obj_data),
        .ent_valid  (ent_valid),
        .ent_ready  (ent_ready),
        .ent_x      (ent_x),
        .ent_code   (ent_code),
        .ent_attr   (ent_attr),
        .ent_row    (ent_row),
        .line_done  (line_done),
        .ovf        (ovf)
    );

    // Object RAM: data appears the clock after the strobe and holds until the next read
    initial forever begin
        @(posedge clk);
        if (obj_rd) obj_data <= ram[obj_addr];
    end

    // Slot costs: 2 ticks when out of range, 6 when collected; the 9th hit ends the scan
    function automatic void buildLine(input logic [7:0] v, input logic b);
        int s;
        int hits;
        logic [7:0] base;
        logic [7:0] diff;
        logic [7:0] attr;
        m_rd_at.delete();
        m_push_at.delete();
        m_ovf_pend = 1'b0;
        s = 1;
        hits = 0;
        m_done_tick = 0;
        for (int slot = 0; slot < 32; slot++) begin
            base = {b, slot[4:0], 2'b00};
            diff = ram[base] + v;
            m_rd_at[s] = base;
            if (diff[7:4] != 4'hF) begin
                m_done_tick = s + 1;
                s = s + 2;
            end else if (hits == 8) begin
                m_ovf_pend = 1'b1;
                m_done_tick = s + 1;
                break;
            end else begin
                for (int w = 1; w < 4; w++) m_rd_at[s + w] = base | 8'(w);
                attr = ram[base | 8'd3];
                m_push_at[s + 5] = {ram[base | 8'd1], ram[base | 8'd2], attr,
                                    attr[1] ? ~diff[3:0] : diff[3:0]};
                hits++;
                m_done_tick = s + 5;
                s = s + 6;
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        model_ok = 1'b1;
        m_rd = 1'b0;
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_ld = 1'b0;
            m_ovf = 1'b0;
            m_addr = 8'd0;
        end else begin
            if (ent_ready && mq.size() != 0) mq.delete(0);
            if (!objon) begin
                mq.delete();
                m_active = 1'b0;
            end else if (pix_ce) begin
                if (line_start) begin
                    buildLine(vline, obj_bank);
                    mq.delete();
                    m_tick = 0;
                    m_active = 1'b1;
                    m_ld = 1'b0;
                    m_ovf = 1'b0;
                end else if (m_active) begin
                    m_tick++;
                    if (m_rd_at.exists(m_tick)) begin
                        m_rd = 1'b1;
                        m_addr = m_rd_at[m_tick];
                    end
                    if (m_push_at.exists(m_tick)) mq.push_back(m_push_at[m_tick]);
                    if (m_tick == m_done_tick) begin
                        m_ld = 1'b1;
                        m_ovf = m_ovf_pend;
                        m_active = 1'b0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison against the model, plus a log of issued read addresses
    initial forever begin
        @(negedge clk);
        if (obj_rd) rd_log.push_back(obj_addr);
        if (model_ok) begin
            m_head = (mq.size() != 0) ? mq[0] : 28'd0;
            checkOutput("obj_rd", 32'(obj_rd), 32'(m_rd));
            checkOutput("obj_addr", 32'(obj_addr), 32'(m_addr));
            checkOutput("line_done", 32'(line_done), 32'(m_ld));
            checkOutput("ovf", 32'(ovf), 32'(m_ovf));
            checkOutput("ent_valid", 32'(ent_valid), 32'(mq.size() != 0));
            checkOutput("entry", 32'({ent_x, ent_code, ent_attr, ent_row}), 32'(m_head));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        phase = (phase + 1) % 8;
        pix_ce = (phase == 7);
        line_start = 1'b0;
        if (rand_ready) ent_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input logic [7:0] v, input logic b);
        while (!pix_ce) step();
        vline = v;
        obj_bank = b;
        line_start = 1'b1;
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (!line_done && n < budget) begin
            step();
            n++;
        end
        checkOutput("line_done reached", 32'(line_done), 32'd1);
    endtask

    task automatic clearRam();
        for (int a = 0; a < 256; a++) ram[a] = 8'h00;
    endtask

    task automatic fillRam(input logic [7:0] v);
        for (int a = 0; a < 256; a++) begin
            if (a[1:0] == 2'd0 && $urandom_range(0, 4) == 0)
                ram[a] = 8'hF0 + 8'($urandom_range(0, 15)) - v;
            else
                ram[a] = 8'($urandom);
        end
    endtask

    initial begin
        clearRam();
        // Reset must win over a coincident line_start/pix_ce
        reset = 1'b1;
        pix_ce = 1'b1;
        line_start = 1'b1;
        objon = 1'b1;
        ent_ready = 1'b1;
        vline = 8'h33;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset obj_rd", 32'(obj_rd), 32'd0);
        checkOutput("reset line_done", 32'(line_done), 32'd0);
        checkOutput("reset ent_valid", 32'(ent_valid), 32'd0);
        reset = 1'b0;
        pix_ce = 1'b0;
        line_start = 1'b0;
        ent_ready = 1'b0;
        phase = 0;
        repeat (4) step();

        // Empty RAM: line_done rises right after the 64th tick
        applyStimulus(8'h00, 1'b0);
        step();
        ticks = 0;
        guard = 0;
        while (ticks < 64 && guard < 2000) begin
            was_ce = pix_ce;
            step();
            guard++;
            if (was_ce) begin
                ticks++;
                if (ticks == 63) checkOutput("empty done early", 32'(line_done), 32'd0);
            end
        end
        checkOutput("empty done at tick 64", 32'(line_done), 32'd1);
        checkOutput("empty no entries", 32'(ent_valid), 32'd0);

        // Single hit in bank 1, slot 3, then the same with vertical flip
        for (int f = 0; f < 2; f++) begin
            clearRam();
            ram[8'h8C] = 8'hF0;
            ram[8'h8D] = 8'h40;
            ram[8'h8E] = 8'h12;
            ram[8'h8F] = (f == 1) ? 8'h02 : 8'h00;
            rd_log.delete();
            applyStimulus(8'h05, 1'b1);
            step();
            waitDone(3000);
            checkOutput("hit entry", 32'({ent_x, ent_code, ent_attr, ent_row}),
                        (f == 1) ? 32'h401202A : 32'h4012005);
            checkOutput("hit read count", 32'(rd_log.size()), 32'd35);
            checkOutput("hit read Y", 32'(rd_log[3]), 32'h8C);
            checkOutput("hit read X", 32'(rd_log[4]), 32'h8D);
            checkOutput("hit read code", 32'(rd_log[5]), 32'h8E);
            checkOutput("hit read attr", 32'(rd_log[6]), 32'h8F);
        end

        // Overflow with backpressure: 10 hits, 8 kept, drained back to back
        clearRam();
        for (int k = 0; k < 10; k++) begin
            ram[k * 4]     = 8'hE0 | 8'(k);
            ram[k * 4 + 1] = 8'h20 + 8'(k);
            ram[k * 4 + 2] = 8'(k);
        end
        rd_log.delete();
        ent_ready = 1'b0;
        applyStimulus(8'h10, 1'b0);
        step();
        waitDone(3000);
        checkOutput("ovf flag", 32'(ovf), 32'd1);
        checkOutput("ovf read count", 32'(rd_log.size()), 32'd33);
        checkOutput("ovf last read", 32'(rd_log[32]), 32'h20);
        ent_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput("drain valid", 32'(ent_valid), 32'd1);
            checkOutput("drain x order", 32'(ent_x), 32'h20 + 32'(k));
            step();
        end
        checkOutput("drain empty", 32'(ent_valid), 32'd0);
        ent_ready = 1'b0;

        // Abort during slot 12 with entries pending
        clearRam();
        for (int k = 0; k < 4; k++) ram[k * 4] = 8'hE0;
        rd_log.delete();
        applyStimulus(8'h10, 1'b0);
        step();
        guard = 0;
        while (!(rd_log.size() != 0 && rd_log[rd_log.size() - 1] == 8'h30) && guard < 3000) begin
            step();
            guard++;
        end
        checkOutput("abort reached slot 12", 32'(guard < 3000), 32'd1);
        checkOutput("abort pre valid", 32'(ent_valid), 32'd1);
        applyStimulus(8'h10, 1'b0);
        step();
        checkOutput("abort flush", 32'(ent_valid), 32'd0);
        checkOutput("abort ovf", 32'(ovf), 32'd0);
        rd_log.delete();
        guard = 0;
        while (rd_log.size() == 0 && guard < 100) begin
            step();
            guard++;
        end
        first_rd = 8'hFF;
        if (rd_log.size() != 0) first_rd = rd_log[0];
        checkOutput("abort restart addr", 32'(first_rd), 32'h00);
        waitDone(3000);

        // Randomized lines with random backpressure, aborts and enable drops
        rand_ready = 1'b1;
        keep_ram = 1'b0;
        for (int l = 0; l < 25; l++) begin
            vl = 8'($urandom);
            bk = 1'($urandom_range(0, 1));
            if (!keep_ram) fillRam(vl);
            applyStimulus(vl, bk);
            step();
            mode = $urandom_range(0, 5);
            keep_ram = 1'b0;
            if (mode == 0) begin
                repeat ($urandom_range(20, 900)) step();
                keep_ram = 1'b1;
            end else if (mode == 1) begin
                repeat ($urandom_range(10, 900)) step();
                objon = 1'b0;
                repeat ($urandom_range(1, 20)) step();
                objon = 1'b1;
                repeat ($urandom_range(1, 20)) step();
            end else begin
                waitDone(3000);
                repeat ($urandom_range(0, 40)) step();
            end
        end

        // Reset in the middle of a scan
        vl = 8'($urandom);
        fillRam(vl);
        applyStimulus(vl, 1'b1);
        step();
        repeat (100) step();
        reset = 1'b1;
        repeat (3) step();
        checkOutput("mid reset ent_valid", 32'(ent_valid), 32'd0);
        checkOutput("mid reset line_done", 32'(line_done), 32'd0);
        reset = 1'b0;
        repeat (10) step();
        applyStimulus(vl, 1'b0);
        step();
        waitDone(3000);
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
